ibuf_wctrl: RTL and testbench

Ping-pong write controller for the input-feature buffer in cnna. Accepts a valid/ready word stream from the DDR read path and writes it into a simple dual-port RAM split into two banks (bank = MSB of write address). It tracks per-bank fill state and frame length, and hands full banks to the main-process reader. The reader returns banks through a release pulse, which gives double buffering between DDR fetch and compute.

---
 rtl/ibuf_wctrl_pkg.sv | 18 +
 rtl/ibuf_bank_trk.sv | 27 ++
 rtl/ibuf_wctrl.sv | 132 +++++++++++++
 tb/tb_ibuf_wctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_wctrl_pkg.sv
// Shared types and constants for the cnna input-feature buffer write controller.
package ibuf_wctrl_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_FILL = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // Width of the optional frame and overflow statistics counters
   localparam int unsigned STAT_W = 16;

   // Each bank gets half of the RAM; the address MSB selects the bank
   function automatic int unsigned bank_depth(input int unsigned asize);
      return 32'd1 << (asize - 1);
   endfunction

endpackage

// File: rtl/ibuf_bank_trk.sv
// Per-bank ready flag and frame length register for the ping-pong input buffer.
module ibuf_bank_trk #(
   parameter int unsigned C_ASIZE = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               close,
   input  logic [C_ASIZE-1:0] len,
   input  logic               rel,
   output logic               rdy,
   output logic [C_ASIZE-1:0] frm_len
);

   // A bank is only filled while free, so close and rel never target the same bank together
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy     <= 1'b0;
         frm_len <= '0;
      end else if (close) begin
         rdy     <= 1'b1;
         frm_len <= len;
      end else if (rel) begin
         rdy     <= 1'b0;
      end
   end

endmodule

// File: rtl/ibuf_wctrl.sv
// Ping-pong write controller for the cnna input-feature buffer.
// Optional statistics counters are enabled by defining IBUF_WCTRL_STAT_EN.
module ibuf_wctrl
   import ibuf_wctrl_pkg::*;
#(
   parameter int unsigned C_DSIZE = 32,
   parameter int unsigned C_ASIZE = 10
) (
   input  logic               I_clk,
   input  logic               I_rst,
   input  logic [C_DSIZE-1:0] I_data,
   input  logic               I_vld,
   input  logic               I_last,
   output logic               O_rdy,
   output logic [C_ASIZE-1:0] O_waddr,
   output logic [C_DSIZE-1:0] O_wdata,
   output logic               O_wr,
   output logic [1:0]         O_bank_rdy,
   output logic [C_ASIZE-1:0] O_len0,
   output logic [C_ASIZE-1:0] O_len1,
   input  logic               I_rel,
   input  logic               I_rel_bank,
   output logic               O_ovf
`ifdef IBUF_WCTRL_STAT_EN
   ,
   output logic [STAT_W-1:0]  O_frm_cnt,
   output logic [STAT_W-1:0]  O_ovf_cnt
`endif
);

   localparam int unsigned        C_BDEPTH = bank_depth(C_ASIZE);
   localparam logic [C_ASIZE-1:0] LAST_OFF = C_ASIZE'(C_BDEPTH - 1);
   localparam logic [C_ASIZE-1:0] ONE      = C_ASIZE'(1);

   state_t             state, state_nxt;
   logic               wb;
   logic [C_ASIZE-1:0] offset;
   logic               rdy_q;
   logic               close_q;
   logic               close_bank;
   logic [C_ASIZE-1:0] close_len;
   logic               fire, wr_now, at_end, close_now, ovf_now, bank_free;

   assign O_rdy     = rdy_q;
   assign fire      = I_vld && rdy_q;
   assign wr_now    = fire && (state == ST_FILL);
   assign at_end    = (offset == LAST_OFF);
   assign close_now = wr_now && (I_last || at_end);
   assign ovf_now   = wr_now && !I_last && at_end;
   // A close is staged one cycle before it reaches the tracker, so count it as occupied
   assign bank_free = !O_bank_rdy[wb] && !(close_q && (close_bank == wb));

   always_ff @(posedge I_clk) begin
      if (I_rst) state <= ST_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT: if (bank_free) state_nxt = ST_FILL;
         ST_FILL: if (fire) begin
            if (I_last)      state_nxt = ST_WAIT;
            else if (at_end) state_nxt = ST_DROP;
         end
         ST_DROP: if (fire && I_last) state_nxt = ST_WAIT;
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         wb         <= 1'b0;
         offset     <= '0;
         rdy_q      <= 1'b0;
         O_wr       <= 1'b0;
         O_waddr    <= '0;
         O_wdata    <= '0;
         close_q    <= 1'b0;
         close_bank <= 1'b0;
         close_len  <= '0;
         O_ovf      <= 1'b0;
      end else begin
         rdy_q      <= (state_nxt != ST_WAIT);
         O_wr       <= wr_now;
         close_q    <= close_now;
         close_bank <= wb;
         close_len  <= offset + ONE;
         O_ovf      <= ovf_now;
         if (wr_now) begin
            O_waddr <= {wb, offset[C_ASIZE-2:0]};
            O_wdata <= I_data;
         end
         if (state == ST_WAIT) offset <= '0;
         else if (wr_now)      offset <= offset + ONE;
         if (fire && I_last)   wb <= ~wb;
      end
   end

   ibuf_bank_trk #(.C_ASIZE(C_ASIZE)) u_trk0 (
      .clk     (I_clk),
      .rst     (I_rst),
      .close   (close_q && !close_bank),
      .len     (close_len),
      .rel     (I_rel && !I_rel_bank),
      .rdy     (O_bank_rdy[0]),
      .frm_len (O_len0)
   );

   ibuf_bank_trk #(.C_ASIZE(C_ASIZE)) u_trk1 (
      .clk     (I_clk),
      .rst     (I_rst),
      .close   (close_q && close_bank),
      .len     (close_len),
      .rel     (I_rel && I_rel_bank),
      .rdy     (O_bank_rdy[1]),
      .frm_len (O_len1)
   );

`ifdef IBUF_WCTRL_STAT_EN
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         O_frm_cnt <= '0;
         O_ovf_cnt <= '0;
      end else begin
         if (close_q)                   O_frm_cnt <= O_frm_cnt + STAT_W'(1);
         if (O_ovf && (O_ovf_cnt != '1)) O_ovf_cnt <= O_ovf_cnt + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ibuf_wctrl.sv
// Scoreboard bench for ibuf_wctrl with an 8-word bank depth.
module tb_ibuf_wctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;

   logic          I_clk = 1'b0;
   logic          I_rst = 1'b1;
   logic [DW-1:0] I_data = '0;
   logic          I_vld = 1'b0;
   logic          I_last = 1'b0;
   logic          O_rdy;
   logic [AW-1:0] O_waddr;
   logic [DW-1:0] O_wdata;
   logic          O_wr;
   logic [1:0]    O_bank_rdy;
   logic [AW-1:0] O_len0, O_len1;
   logic          I_rel = 1'b0;
   logic          I_rel_bank = 1'b0;
   logic          O_ovf;
`ifdef IBUF_WCTRL_STAT_EN
   logic [15:0]   O_frm_cnt, O_ovf_cnt;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned ovf_seen = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic             mwb;
   int unsigned      moff;
   logic             mdrop;

   always #5 I_clk = ~I_clk;

   ibuf_wctrl #(.C_DSIZE(DW), .C_ASIZE(AW)) dut (
      .I_clk      (I_clk),
      .I_rst      (I_rst),
      .I_data     (I_data),
      .I_vld      (I_vld),
      .I_last     (I_last),
      .O_rdy      (O_rdy),
      .O_waddr    (O_waddr),
      .O_wdata    (O_wdata),
      .O_wr       (O_wr),
      .O_bank_rdy (O_bank_rdy),
      .O_len0     (O_len0),
      .O_len1     (O_len1),
      .I_rel      (I_rel),
      .I_rel_bank (I_rel_bank),
      .O_ovf      (O_ovf)
`ifdef IBUF_WCTRL_STAT_EN
      ,
      .O_frm_cnt  (O_frm_cnt),
      .O_ovf_cnt  (O_ovf_cnt)
`endif
   );

   // Reference model of one accepted beat: 8-word banks, bank = address MSB
   task automatic model_transfer(input logic [DW-1:0] d, input logic l);
      logic [AW-2:0] off;
      if (!mdrop) begin
         off = (AW-1)'(moff);
         exp_q.push_back({mwb, off, d});
         if (l) begin
            mwb  = ~mwb;
            moff = 0;
         end else if (moff == 7) begin
            mdrop = 1'b1;
         end else begin
            moff++;
         end
      end else if (l) begin
         mdrop = 1'b0;
         mwb   = ~mwb;
         moff  = 0;
      end
   endtask

   task automatic monitor();
      logic [AW+DW-1:0] e;
      forever begin
         @(negedge I_clk);
         if (O_ovf === 1'b1) ovf_seen++;
         if (O_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got addr %h data %h, required no write", O_waddr, O_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({O_waddr, O_wdata} !== e)
                  begin
                     errors++;
                     $display("FAIL wr_data: got addr %h data %h, required addr %h data %h",
                              O_waddr, O_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                  end
            end
         end
      end
   endtask

   // Starts at a falling edge, returns just after the rising edge that carries the beat
   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int unsigned n;
      n = 0;
      @(negedge I_clk);
      I_vld = 1'b1; I_data = d; I_last = l;
      while (O_rdy !== 1'b1 && n < 200) begin
         @(negedge I_clk);
         n++;
      end
      checks++;
      if (O_rdy !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout: O_rdy got %b required 1", O_rdy);
      end else begin
         model_transfer(d, l);
      end
      @(posedge I_clk);
   endtask

   task automatic send_frame(input int unsigned n, input logic [DW-1:0] base, input logic last);
      for (int unsigned i = 0; i < n; i++)
         send_beat(base + DW'(i), last && (i == n - 1));
   endtask

   task automatic do_reset();
      @(negedge I_clk);
      I_rst = 1'b1; I_vld = 1'b0; I_last = 1'b0; I_rel = 1'b0; I_rel_bank = 1'b0; I_data = '0;
      repeat (2) @(negedge I_clk);
      checks++;
      if ({O_rdy, O_wr, O_ovf, O_bank_rdy} !== 5'b0) begin
         errors++;
         $display("FAIL rst_ctrl: got rdy %b wr %b ovf %b bank_rdy %b, required all 0",
                  O_rdy, O_wr, O_ovf, O_bank_rdy);
      end
      checks++;
      if (O_waddr !== '0 || O_wdata !== '0 || O_len0 !== '0 || O_len1 !== '0) begin
         errors++;
         $display("FAIL rst_data: got waddr %h wdata %h len0 %h len1 %h, required all 0",
                  O_waddr, O_wdata, O_len0, O_len1);
      end
`ifdef IBUF_WCTRL_STAT_EN
      checks++;
      if (O_frm_cnt !== 16'd0 || O_ovf_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_stat: got frm %0d ovf %0d, required 0 0", O_frm_cnt, O_ovf_cnt);
      end
`endif
      I_rst = 1'b0;
      mwb = 1'b0; moff = 0; mdrop = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk_bank(input string name, input logic [1:0] rdy, input logic [AW-1:0] l0,
                           input logic chk0, input logic [AW-1:0] l1, input logic chk1);
      checks++;
      if (O_bank_rdy !== rdy || (chk0 && O_len0 !== l0) || (chk1 && O_len1 !== l1)) begin
         errors++;
         $display("FAIL %s: got bank_rdy %b len0 %0d len1 %0d, required bank_rdy %b len0 %0d len1 %0d",
                  name, O_bank_rdy, O_len0, O_len1, rdy, l0, l1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge I_clk);
      checks++;
      if (O_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rdy_rise: got %b required 1", O_rdy);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_frame(5, 32'h1, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      chk_bank("basic_k1", 2'b00, '0, 1'b0, '0, 1'b0);
      @(negedge I_clk);
      chk_bank("basic_k2", 2'b01, 4'd5, 1'b1, '0, 1'b0);
      I_rel = 1'b1; I_rel_bank = 1'b0;
      @(negedge I_clk);
      I_rel = 1'b0;
      chk_bank("basic_rel", 2'b00, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_pingpong();
      do_reset();
      send_frame(3, 32'hA0, 1'b1);
      send_frame(4, 32'hB0, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (4) @(negedge I_clk);
      checks++;
      if (O_rdy !== 1'b0) begin
         errors++;
         $display("FAIL pp_stall: O_rdy got %b required 0", O_rdy);
      end
      chk_bank("pp_full", 2'b11, 4'd3, 1'b1, 4'd4, 1'b1);
      I_rel = 1'b1; I_rel_bank = 1'b0;
      @(negedge I_clk);
      I_rel = 1'b0;
      chk_bank("pp_rel", 2'b10, '0, 1'b0, 4'd4, 1'b1);
      checks++;
      if (O_rdy !== 1'b0) begin
         errors++;
         $display("FAIL pp_rel_rdy_k1: O_rdy got %b required 0", O_rdy);
      end
      @(negedge I_clk);
      checks++;
      if (O_rdy !== 1'b1) begin
         errors++;
         $display("FAIL pp_rel_rdy_k2: O_rdy got %b required 1", O_rdy);
      end
      send_frame(2, 32'hC0, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (2) @(negedge I_clk);
      chk_bank("pp_third", 2'b11, 4'd2, 1'b1, 4'd4, 1'b1);
   endtask

   task automatic test_overflow();
      int unsigned ov0;
      do_reset();
      ov0 = ovf_seen;
      send_frame(11, 32'h100, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (3) @(negedge I_clk);
      checks++;
      if (ovf_seen - ov0 !== 1) begin
         errors++;
         $display("FAIL ovf_pulses: got %0d required 1", ovf_seen - ov0);
      end
      chk_bank("ovf_len", 2'b01, 4'd8, 1'b1, '0, 1'b0);
      send_frame(2, 32'h200, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (2) @(negedge I_clk);
      chk_bank("ovf_next", 2'b11, 4'd8, 1'b1, 4'd2, 1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_pending: got %0d outstanding writes required 0", exp_q.size());
      end
   endtask

   task automatic test_exact();
      int unsigned ov0;
      do_reset();
      ov0 = ovf_seen;
      send_frame(8, 32'h400, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (2) @(negedge I_clk);
      checks++;
      if (ovf_seen != ov0) begin
         errors++;
         $display("FAIL exact_ovf: got %0d pulses required 0", ovf_seen - ov0);
      end
      chk_bank("exact_len", 2'b01, 4'd8, 1'b1, '0, 1'b0);
   endtask

   task automatic test_simul();
      do_reset();
      send_frame(3, 32'h300, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      @(negedge I_clk);
      I_rel = 1'b1; I_rel_bank = 1'b0;
      @(negedge I_clk);
      I_rel = 1'b0;
      send_frame(2, 32'h310, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      @(negedge I_clk);
      chk_bank("sim_b1", 2'b10, '0, 1'b0, 4'd2, 1'b1);
      send_frame(3, 32'h320, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0; I_rel = 1'b1; I_rel_bank = 1'b1;
      chk_bank("sim_k1", 2'b10, '0, 1'b0, 4'd2, 1'b1);
      @(negedge I_clk);
      I_rel = 1'b0;
      chk_bank("sim_k2", 2'b01, 4'd3, 1'b1, '0, 1'b0);
      I_rel = 1'b1; I_rel_bank = 1'b1;
      @(negedge I_clk);
      I_rel = 1'b0;
      chk_bank("sim_free_rel", 2'b01, 4'd3, 1'b1, '0, 1'b0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_frame(4, 32'h500, 1'b1);
      send_frame(3, 32'h600, 1'b0);
      @(negedge I_clk);
      I_vld = 1'b0;
      do_reset();
      send_frame(2, 32'h700, 1'b1);
      @(negedge I_clk);
      I_vld = 1'b0;
      repeat (2) @(negedge I_clk);
      chk_bank("rstmid_next", 2'b01, 4'd2, 1'b1, '0, 1'b0);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_pingpong();
      test_overflow();
      test_exact();
      test_simul();
      test_reset_mid();
      repeat (2) @(negedge I_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL end_pending: got %0d outstanding writes required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
